// File: rtl/cla_addsub_pipe_if.sv
// cla_addsub_pipe_if: operand/result handshake bus (in: in_valid/in_ready a b cin sub; out: out_valid/out_ready sum cout ovf zero neg)
interface cla_addsub_pipe_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero, neg;
  logic [WIDTH-1:0] a, b, sum;
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, neg
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg
  );
endinterface

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: STAGES-deep pipelined CLA adder/subtractor; clk, rst (sync, high), bus.slave carries in/out valid-ready, a, b, cin, sub, sum, cout, ovf, zero, neg
module cla_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input logic clk,
  input logic rst,
  cla_addsub_pipe_if.slave bus
);
  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / GROUP;
  localparam int L  = STAGES - 1;
  logic adv;
  function automatic logic [SW:0] cla(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic ci);
    logic [SW-1:0] p, g, c;
    logic [NG-1:0] gp, gg;
    logic [NG:0] gc;
    p = x ^ y;
    g = x & y;
    gc[0] = ci;
    for (int j = 0; j < NG; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & gg[j]);
        gp[j] = gp[j] & p[j*GROUP+i];
      end
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
      c[j*GROUP] = gc[j];
      for (int i = 1; i < GROUP; i++)
        c[j*GROUP+i] = g[j*GROUP+i-1] | (p[j*GROUP+i-1] & c[j*GROUP+i-1]);
    end
    return {gc[NG], p ^ c};
  endfunction
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int HW = WIDTH - k * SW;
    logic [HW-1:0] ia, ib;
    logic ic, iv;
    logic [SW:0] r;
    logic [(k+1)*SW-1:0] ns;
    assign r = cla(ia[SW-1:0], ib[SW-1:0], ic);
    if (k == 0) begin : g_in
      assign ia = bus.a;
      assign ib = bus.b ^ {WIDTH{bus.sub}};
      assign ic = bus.sub | bus.cin;
      assign iv = bus.in_valid;
      assign ns = r[SW-1:0];
    end else begin : g_reg
      logic [k*SW-1:0] is;
      always_ff @(posedge clk) begin
        if (rst) iv <= 1'b0;
        else if (adv) begin
          iv <= g_st[k-1].iv;
          ia <= g_st[k-1].ia[HW+SW-1:SW];
          ib <= g_st[k-1].ib[HW+SW-1:SW];
          ic <= g_st[k-1].r[SW];
          is <= g_st[k-1].ns;
        end
      end
      assign ns = {r[SW-1:0], is};
    end
  end
  logic [WIDTH-1:0] s;
  logic v, c, o, ma;
  assign s  = g_st[L].ns;
  assign v  = g_st[L].iv;
  assign c  = g_st[L].r[SW];
  assign ma = g_st[L].ia[SW-1];
  assign o  = (ma ~^ g_st[L].ib[SW-1]) & (s[WIDTH-1] ^ ma);
  always_ff @(posedge clk) begin
    if (rst || (adv && !v)) {bus.out_valid, bus.cout, bus.ovf, bus.zero, bus.neg, bus.sum} <= '0;
    else if (adv) {bus.out_valid, bus.cout, bus.ovf, bus.zero, bus.neg, bus.sum} <= {1'b1, c, o, ~|s, s[WIDTH-1], s};
  end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb_cla_addsub_pipe: randomized and directed checks of three cla_addsub_pipe configurations against an arithmetic model
module tb_cla_addsub_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int sel = 0;
  int checks = 0;
  int errors = 0;
  logic in_valid = 1'b0, sub_d = 1'b0, cin_d = 1'b0, out_ready = 1'b1;
  logic [31:0] a_d = '0, b_d = '0;
  cla_addsub_pipe_if #(.WIDTH(32)) b0();
  cla_addsub_pipe_if #(.WIDTH(16)) b1();
  cla_addsub_pipe_if #(.WIDTH(16)) b2();
  cla_addsub_pipe #(.WIDTH(32), .GROUP(4), .STAGES(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
  cla_addsub_pipe #(.WIDTH(16), .GROUP(4), .STAGES(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  cla_addsub_pipe #(.WIDTH(16), .GROUP(4), .STAGES(4)) u2 (.clk(clk), .rst(rst), .bus(b2));
  assign b0.in_valid = in_valid && sel == 0;
  assign b1.in_valid = in_valid && sel == 1;
  assign b2.in_valid = in_valid && sel == 2;
  assign b0.a = a_d;
  assign b1.a = a_d[15:0];
  assign b2.a = a_d[15:0];
  assign b0.b = b_d;
  assign b1.b = b_d[15:0];
  assign b2.b = b_d[15:0];
  assign {b0.sub, b1.sub, b2.sub} = {3{sub_d}};
  assign {b0.cin, b1.cin, b2.cin} = {3{cin_d}};
  assign {b0.out_ready, b1.out_ready, b2.out_ready} = {3{out_ready}};
  logic o_valid, o_ready;
  logic [35:0] o_res;
  assign o_valid = sel == 0 ? b0.out_valid : sel == 1 ? b1.out_valid : b2.out_valid;
  assign o_ready = sel == 0 ? b0.in_ready : sel == 1 ? b1.in_ready : b2.in_ready;
  assign o_res = sel == 0 ? {b0.cout, b0.ovf, b0.zero, b0.neg, b0.sum}
               : sel == 1 ? {b1.cout, b1.ovf, b1.zero, b1.neg, 16'h0, b1.sum}
               :            {b2.cout, b2.ovf, b2.zero, b2.neg, 16'h0, b2.sum};
  function automatic int wid();
    return sel == 0 ? 32 : 16;
  endfunction
  function automatic int lat();
    return sel == 0 ? 2 : sel == 1 ? 1 : 4;
  endfunction
  function automatic logic [31:0] msk();
    return sel == 0 ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction
  // Result as {cout, ovf, zero, neg, sum}; from unsigned and signed integer arithmetic.
  function automatic logic [35:0] model(int w, logic [31:0] a, logic [31:0] b, logic s, logic ci);
    longint one, ua, ub, sa, sb, r, sr;
    logic co, ov;
    logic [31:0] sm;
    one = 1;
    ua = longint'(a);
    ub = longint'(b);
    sa = ua >= (one << (w - 1)) ? ua - (one << w) : ua;
    sb = ub >= (one << (w - 1)) ? ub - (one << w) : ub;
    if (s) begin
      r  = ua - ub;
      co = ua >= ub;
      sr = sa - sb;
    end else begin
      r  = ua + ub + longint'(ci);
      co = r >= (one << w);
      sr = sa + sb + longint'(ci);
    end
    sm = 32'(r & ((one << w) - 1));
    ov = sr > (one << (w - 1)) - 1 || sr < -(one << (w - 1));
    return {co, ov, sm == 0, sm[w-1], sm};
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (config %0d): got %h expected %h", tag, sel, got, exp);
    end
  endtask
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_outputs", 64'(o_res), 64'd0);
    check("rst_in_ready", 64'(o_ready), 64'd1);
  endtask
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic ci,
                      output logic [35:0] got, output int n);
    int t;
    @(negedge clk);
    a_d = a;
    b_d = b;
    sub_d = s;
    cin_d = ci;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    t = 0;
    while (!o_ready && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n = 1;
    while (!o_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    got = o_res;
  endtask
  logic [31:0] da32 [4] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'h8000_0000};
  logic [31:0] da16 [4] = '{32'h0000_FFFF, 32'h0000_7FFF, 32'd5, 32'h0000_8000};
  logic [31:0] db   [4] = '{32'd1, 32'd0, 32'd7, 32'd1};
  logic        ds   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic        dc   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [35:0] de32 [4] = '{{4'b1010, 32'h0}, {4'b0101, 32'h8000_0000}, {4'b0001, 32'hFFFF_FFFE}, {4'b1100, 32'h7FFF_FFFF}};
  logic [35:0] de16 [4] = '{{4'b1010, 32'h0}, {4'b0101, 32'h0000_8000}, {4'b0001, 32'h0000_FFFE}, {4'b1100, 32'h0000_7FFF}};
  task automatic directed();
    logic [35:0] got;
    int n;
    for (int i = 0; i < 4; i++) begin
      send(sel == 0 ? da32[i] : da16[i], db[i], ds[i], dc[i], got, n);
      check($sformatf("dir%0d_latency", i), 64'(n), 64'(lat()));
      check($sformatf("dir%0d_result", i), 64'(got), 64'(sel == 0 ? de32[i] : de16[i]));
    end
  endtask
  task automatic random_ops();
    logic [35:0] got;
    logic [31:0] a, b;
    logic s, ci;
    int n;
    for (int i = 0; i < 6; i++) begin
      a = $urandom & msk();
      b = $urandom & msk();
      s = 1'($urandom_range(1));
      ci = 1'($urandom_range(1));
      send(a, b, s, ci, got, n);
      check("rand_latency", 64'(n), 64'(lat()));
      check("rand_result", 64'(got), 64'(model(wid(), a, b, s, ci)));
    end
  endtask
  task automatic stream();
    logic [35:0] expq [$];
    logic [31:0] qa [8], qb [8];
    logic qs [8], qc [8];
    logic stall_prev;
    logic [36:0] held;
    int ni, no, cyc;
    for (int i = 0; i < 8; i++) begin
      qa[i] = $urandom & msk();
      qb[i] = $urandom & msk();
      qs[i] = 1'($urandom_range(1));
      qc[i] = 1'($urandom_range(1));
    end
    ni = 0;
    no = 0;
    cyc = 0;
    stall_prev = 1'b0;
    held = '0;
    while (no < 8 && cyc < 100) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid = ni < 8;
      if (ni < 8) begin
        a_d = qa[ni];
        b_d = qb[ni];
        sub_d = qs[ni];
        cin_d = qc[ni];
      end
      #1;
      check("stream_in_ready", 64'(o_ready), 64'(!(o_valid && !out_ready)));
      if (stall_prev) check("stream_hold", 64'({o_valid, o_res}), 64'(held));
      if (!o_valid) check("stream_idle_zero", 64'(o_res), 64'd0);
      if (o_valid && out_ready) begin
        check("stream_not_extra", 64'(expq.size() > 0), 64'd1);
        if (expq.size() > 0) check("stream_result", 64'(o_res), 64'(expq.pop_front()));
        no++;
      end
      stall_prev = o_valid && !out_ready;
      held = {o_valid, o_res};
      if (in_valid && o_ready) begin
        expq.push_back(model(wid(), qa[ni], qb[ni], qs[ni], qc[ni]));
        ni++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 64'(no), 64'd8);
    check("stream_leftover", 64'(expq.size()), 64'd0);
  endtask
  task automatic mid_reset();
    @(negedge clk);
    out_ready = 1'b1;
    a_d = $urandom & msk();
    b_d = $urandom & msk();
    sub_d = 1'b0;
    cin_d = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    a_d = $urandom & msk();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_outputs", 64'(o_res), 64'd0);
    check("midrst_in_ready", 64'(o_ready), 64'd1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("postrst_no_stale", 64'({o_valid, o_res}), 64'd0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    for (int s = 0; s < 3; s++) begin
      sel = s;
      reset_dut();
      directed();
      random_ops();
      stream();
      mid_reset();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
